// File: rtl/dcache_store_queue.sv
// dcache_store_queue
//
// In-order committed-store queue feeding the store port of the L1 data cache.
// Committed stores enter on a valid/ready interface and are buffered in a
// circular FIFO. The head entry is presented to the dcache with a req/gnt
// handshake, one store at a time. The queue also gives the load path a
// same-8-byte-word hazard check and gives fence/flush logic an empty flag.
//
// Optional feature macro: STBUF_COALESCE_EN
//   When defined, a store to the same 8-byte word as the youngest entry is
//   merged into that entry, provided the youngest entry is not the head.
//   When undefined, every accepted store takes its own entry.
//
// Parameters:
//   DEPTH        number of entries (power of two, >= 2)
//   INDEX_WIDTH  dcache index width (page-offset bits)
//   TAG_WIDTH    dcache tag width
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drain request; blocks new stores while high
//   empty_o                queue holds no entries
//   st_valid_i/st_ready_o  committed-store handshake
//   st_paddr_i/st_data_i/st_be_i   store address, word-aligned data, byte enables
//   ld_index_i/ld_match_o  load page-offset and same-word hazard flag
//   req_o/gnt_i            dcache write handshake (write completes on grant)
//   index_o/tag_o/we_o/wdata_o/be_o  dcache write request payload
module dcache_store_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = 44
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  output logic                             empty_o,
  input  logic                             st_valid_i,
  output logic                             st_ready_o,
  input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] st_paddr_i,
  input  logic [63:0]                      st_data_i,
  input  logic [7:0]                       st_be_i,
  input  logic [INDEX_WIDTH-1:0]           ld_index_i,
  output logic                             ld_match_o,
  output logic                             req_o,
  input  logic                             gnt_i,
  output logic [INDEX_WIDTH-1:0]           index_o,
  output logic [TAG_WIDTH-1:0]             tag_o,
  output logic                             we_o,
  output logic [63:0]                      wdata_o,
  output logic [7:0]                       be_o
);

  localparam int unsigned PA_W   = INDEX_WIDTH + TAG_WIDTH;
  localparam int unsigned WORD_W = PA_W - 3;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Only the 8-byte word address is kept; the byte offset never matters.
  logic [WORD_W-1:0] word_q [DEPTH];
  logic [63:0]       data_q [DEPTH];
  logic [7:0]        be_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic coalesce_hit;
  logic accept;
  logic push;
  logic pop;

  // Byte-offset bits of both addresses are intentionally ignored.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{st_paddr_i[2:0], ld_index_i[2:0]};

`ifdef STBUF_COALESCE_EN
  // Youngest entry; with count>=2 it can never be the head, so it is safe to
  // modify even if the head is being granted this cycle.
  logic [PTR_W-1:0] last_ptr;
  assign last_ptr = wr_ptr - PTR_W'(1);

  assign coalesce_hit = st_valid_i && (count >= CNT_W'(2)) &&
                        (st_paddr_i[PA_W-1:3] == word_q[last_ptr]);
`else
  assign coalesce_hit = 1'b0;
`endif

  // Ready ignores gnt_i on purpose: a full queue does not take a store in
  // the same cycle the head is granted.
  assign st_ready_o = !flush_i && ((count < FULL) || coalesce_hit);
  assign accept     = st_valid_i && st_ready_o;
  assign push       = accept && !coalesce_hit;
  assign pop        = req_o && gnt_i;

  assign req_o   = (count != '0);
  assign empty_o = (count == '0);
  assign we_o    = 1'b1;
  assign index_o = {word_q[rd_ptr][INDEX_WIDTH-4:0], 3'b000};
  assign tag_o   = word_q[rd_ptr][WORD_W-1:INDEX_WIDTH-3];
  assign wdata_o = data_q[rd_ptr];
  assign be_o    = be_q[rd_ptr];

  // Address and data storage carry no reset; their contents are don't-care
  // until written and a mid-operation reset simply discards them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q[wr_ptr] <= st_paddr_i[PA_W-1:3];
      data_q[wr_ptr] <= st_data_i;
    end
`ifdef STBUF_COALESCE_EN
    else if (accept && coalesce_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be_i[b]) begin
          data_q[last_ptr][8*b +: 8] <= st_data_i[8*b +: 8];
        end
      end
    end
`endif
  end

  // Byte enables are cleared on reset so the head payload is benign.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        be_q[i] <= '0;
      end
    end else if (push) begin
      be_q[wr_ptr] <= st_be_i;
    end
`ifdef STBUF_COALESCE_EN
    else if (accept && coalesce_hit) begin
      be_q[last_ptr] <= be_q[last_ptr] | st_be_i;
    end
`endif
  end

  // Pointers and occupancy; simultaneous push and pop leaves count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below count. The
  // check ignores byte enables, so it may report a conservative match.
  always_comb begin
    logic [PTR_W-1:0] offset;
    ld_match_o = 1'b0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if (({1'b0, offset} < count) &&
          (word_q[i][INDEX_WIDTH-4:0] == ld_index_i[INDEX_WIDTH-1:3])) begin
        ld_match_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_store_queue.sv
// tb_dcache_store_queue
//
// Self-checking bench for dcache_store_queue (default parameters). A table
// of per-cycle vectors covers reset, single store, fill/back-pressure, load
// hazard and flush; hand-written sequences cover random-grant wrap-around,
// store coalescing (expectations follow STBUF_COALESCE_EN) and a reset in
// the middle of operation.
module tb_dcache_store_queue;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        empty_o;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [55:0] st_paddr_i;
  logic [63:0] st_data_i;
  logic [7:0]  st_be_i;
  logic [11:0] ld_index_i;
  logic        ld_match_o;
  logic        req_o;
  logic        gnt_i;
  logic [11:0] index_o;
  logic [43:0] tag_o;
  logic        we_o;
  logic [63:0] wdata_o;
  logic [7:0]  be_o;

  int total = 0;
  int bad   = 0;

  dcache_store_queue dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .empty_o    (empty_o),
    .st_valid_i (st_valid_i),
    .st_ready_o (st_ready_o),
    .st_paddr_i (st_paddr_i),
    .st_data_i  (st_data_i),
    .st_be_i    (st_be_i),
    .ld_index_i (ld_index_i),
    .ld_match_o (ld_match_o),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .index_o    (index_o),
    .tag_o      (tag_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o),
    .be_o       (be_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic        valid;
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        gnt;
    logic        flush;
    logic [11:0] ld;
    logic        e_ready;
    logic        e_req;
    logic        e_empty;
    logic        e_match;
    logic [55:0] e_paddr;
    logic [63:0] e_data;
    logic [7:0]  e_be;
  } vec_t;

  typedef struct {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
  } entry_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [55:0] paddr,
                              input logic [63:0] data, input logic [7:0] be,
                              input logic gnt, input logic flush, input logic [11:0] ld,
                              input logic e_ready, input logic e_req,
                              input logic e_empty, input logic e_match,
                              input logic [55:0] e_paddr, input logic [63:0] e_data,
                              input logic [7:0] e_be);
    vec_t v;
    v.valid = valid;  v.paddr = paddr;  v.data = data;  v.be = be;
    v.gnt = gnt;  v.flush = flush;  v.ld = ld;
    v.e_ready = e_ready;  v.e_req = e_req;  v.e_empty = e_empty;  v.e_match = e_match;
    v.e_paddr = e_paddr;  v.e_data = e_data;  v.e_be = e_be;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    st_valid_i = v.valid;
    st_paddr_i = v.paddr;
    st_data_i  = v.data;
    st_be_i    = v.be;
    gnt_i      = v.gnt;
    flush_i    = v.flush;
    ld_index_i = v.ld;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    chk({tag, ".ready"}, 64'(st_ready_o), 64'(v.e_ready));
    chk({tag, ".req"},   64'(req_o),      64'(v.e_req));
    chk({tag, ".empty"}, 64'(empty_o),    64'(v.e_empty));
    chk({tag, ".match"}, 64'(ld_match_o), 64'(v.e_match));
    if (v.e_req) begin
      chk({tag, ".index"}, 64'(index_o), 64'({v.e_paddr[11:3], 3'b000}));
      chk({tag, ".tag"},   64'(tag_o),   64'(v.e_paddr[55:12]));
      chk({tag, ".wdata"}, wdata_o,      v.e_data);
      chk({tag, ".be"},    64'(be_o),    64'(v.e_be));
      chk({tag, ".we"},    64'(we_o),    64'd1);
    end
  endtask

  // Drive one idle cycle's worth of inputs and expect a grant-driven head.
  task automatic expectHead(input entry_t e, input string tag);
    @(negedge clk_i);
    st_valid_i = 1'b0;
    gnt_i      = 1'b1;
    flush_i    = 1'b0;
    #1;
    chk({tag, ".req"},   64'(req_o),   64'd1);
    chk({tag, ".index"}, 64'(index_o), 64'({e.paddr[11:3], 3'b000}));
    chk({tag, ".tag"},   64'(tag_o),   64'(e.paddr[55:12]));
    chk({tag, ".wdata"}, wdata_o,      e.data);
    chk({tag, ".be"},    64'(be_o),    64'(e.be));
  endtask

  function automatic logic [55:0] sAddr(input int k);
    return {44'h12345, 12'h100 + 12'(8 * k)};
  endfunction
  function automatic logic [63:0] sData(input int k);
    return 64'hD0D0_0000_0000_0000 | 64'(k);
  endfunction
  function automatic logic [7:0] sBe(input int k);
    return 8'hF0 | 8'(k);
  endfunction
  function automatic logic [55:0] fAddr(input int k);
    return {44'h7, 12'h200 + 12'(8 * k)};
  endfunction

  vec_t vecs[$];

  initial begin
    logic [55:0] p1;
    logic [63:0] d1;
    logic [55:0] ph;
    logic [63:0] dh;
    entry_t      q[$];
    entry_t      e;
    int          sent;
    int          got;
    logic        exp_ready;

    p1 = 56'h0000_0000_8000_0010;
    d1 = 64'h1122_3344_5566_7788;
    ph = {44'h00ABC, 12'h0A8};
    dh = 64'hCAFE_0000_0000_BEEF;

    // Single store with grant held high
    vecs.push_back(mk(1, p1, d1, 8'hFF, 1, 0, 12'h000, 1, 0, 1, 0, '0, '0, '0));
    vecs.push_back(mk(0, '0, '0, '0,    1, 0, 12'h010, 1, 1, 0, 1, p1, d1, 8'hFF));
    vecs.push_back(mk(0, '0, '0, '0,    0, 0, 12'h010, 1, 0, 1, 0, '0, '0, '0));
    // Fill with gnt low, 5th store stalls, one grant frees a slot a cycle later
    vecs.push_back(mk(1, sAddr(1), sData(1), sBe(1), 0, 0, 12'h000, 1, 0, 1, 0, '0, '0, '0));
    vecs.push_back(mk(1, sAddr(2), sData(2), sBe(2), 0, 0, 12'h000, 1, 1, 0, 0, sAddr(1), sData(1), sBe(1)));
    vecs.push_back(mk(1, sAddr(3), sData(3), sBe(3), 0, 0, 12'h000, 1, 1, 0, 0, sAddr(1), sData(1), sBe(1)));
    vecs.push_back(mk(1, sAddr(4), sData(4), sBe(4), 0, 0, 12'h000, 1, 1, 0, 0, sAddr(1), sData(1), sBe(1)));
    vecs.push_back(mk(1, sAddr(5), sData(5), sBe(5), 0, 0, 12'h000, 0, 1, 0, 0, sAddr(1), sData(1), sBe(1)));
    vecs.push_back(mk(1, sAddr(5), sData(5), sBe(5), 1, 0, 12'h000, 0, 1, 0, 0, sAddr(1), sData(1), sBe(1)));
    vecs.push_back(mk(1, sAddr(5), sData(5), sBe(5), 0, 0, 12'h000, 1, 1, 0, 0, sAddr(2), sData(2), sBe(2)));
    vecs.push_back(mk(0, '0, '0, '0, 1, 0, 12'h000, 0, 1, 0, 0, sAddr(2), sData(2), sBe(2)));
    vecs.push_back(mk(0, '0, '0, '0, 1, 0, 12'h000, 1, 1, 0, 0, sAddr(3), sData(3), sBe(3)));
    vecs.push_back(mk(0, '0, '0, '0, 1, 0, 12'h000, 1, 1, 0, 0, sAddr(4), sData(4), sBe(4)));
    vecs.push_back(mk(0, '0, '0, '0, 1, 0, 12'h000, 1, 1, 0, 0, sAddr(5), sData(5), sBe(5)));
    vecs.push_back(mk(0, '0, '0, '0, 1, 0, 12'h000, 1, 0, 1, 0, '0, '0, '0));
    // Load hazard on word 0x0A8
    vecs.push_back(mk(1, ph, dh, 8'h0F, 0, 0, 12'h0AC, 1, 0, 1, 0, '0, '0, '0));
    vecs.push_back(mk(0, '0, '0, '0,    0, 0, 12'h0AC, 1, 1, 0, 1, ph, dh, 8'h0F));
    vecs.push_back(mk(0, '0, '0, '0,    0, 0, 12'h0B0, 1, 1, 0, 0, ph, dh, 8'h0F));
    vecs.push_back(mk(0, '0, '0, '0,    1, 0, 12'h0A8, 1, 1, 0, 1, ph, dh, 8'h0F));
    vecs.push_back(mk(0, '0, '0, '0,    0, 0, 12'h0AC, 1, 0, 1, 0, '0, '0, '0));
    // Flush with three entries queued
    vecs.push_back(mk(1, fAddr(1), sData(11), 8'h11, 0, 0, 12'h000, 1, 0, 1, 0, '0, '0, '0));
    vecs.push_back(mk(1, fAddr(2), sData(12), 8'h12, 0, 0, 12'h000, 1, 1, 0, 0, fAddr(1), sData(11), 8'h11));
    vecs.push_back(mk(1, fAddr(3), sData(13), 8'h13, 0, 0, 12'h000, 1, 1, 0, 0, fAddr(1), sData(11), 8'h11));
    vecs.push_back(mk(1, fAddr(4), sData(14), 8'h14, 0, 1, 12'h000, 0, 1, 0, 0, fAddr(1), sData(11), 8'h11));
    vecs.push_back(mk(1, fAddr(4), sData(14), 8'h14, 1, 1, 12'h000, 0, 1, 0, 0, fAddr(1), sData(11), 8'h11));
    vecs.push_back(mk(1, fAddr(4), sData(14), 8'h14, 1, 1, 12'h000, 0, 1, 0, 0, fAddr(2), sData(12), 8'h12));
    vecs.push_back(mk(1, fAddr(4), sData(14), 8'h14, 1, 1, 12'h000, 0, 1, 0, 0, fAddr(3), sData(13), 8'h13));
    vecs.push_back(mk(1, fAddr(4), sData(14), 8'h14, 1, 1, 12'h000, 0, 0, 1, 0, '0, '0, '0));
    vecs.push_back(mk(0, '0, '0, '0, 0, 0, 12'h218, 1, 0, 1, 0, '0, '0, '0));

    // Reset state
    rst_ni = 1'b0;
    flush_i = 1'b0;  st_valid_i = 1'b0;  st_paddr_i = '0;  st_data_i = '0;
    st_be_i = '0;  gnt_i = 1'b0;  ld_index_i = '0;
    #1;
    chk("reset.empty", 64'(empty_o),    64'd1);
    chk("reset.req",   64'(req_o),      64'd0);
    chk("reset.match", 64'(ld_match_o), 64'd0);
    chk("reset.ready", 64'(st_ready_o), 64'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    chk("reset.ready_flush", 64'(st_ready_o), 64'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    rst_ni  = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Wrap-around: 10 stores with random grants against a FIFO model
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge clk_i);
      flush_i    = 1'b0;
      ld_index_i = '0;
      st_valid_i = (sent < 10);
      st_paddr_i = {44'(sent + 1), 12'h300 + 12'(8 * sent)};
      st_data_i  = {32'(sent), 32'($urandom)};
      st_be_i    = 8'(sent + 1);
      gnt_i      = 1'($urandom_range(0, 1));
      #1;
      exp_ready = (q.size() < 4);
      chk("wrap.ready", 64'(st_ready_o), 64'(exp_ready));
      chk("wrap.req",   64'(req_o),      64'(q.size() != 0));
      if (q.size() != 0 && gnt_i) begin
        e = q.pop_front();
        chk($sformatf("wrap.w%0d.index", got), 64'(index_o), 64'({e.paddr[11:3], 3'b000}));
        chk($sformatf("wrap.w%0d.tag", got),   64'(tag_o),   64'(e.paddr[55:12]));
        chk($sformatf("wrap.w%0d.wdata", got), wdata_o,      e.data);
        chk($sformatf("wrap.w%0d.be", got),    64'(be_o),    64'(e.be));
        got++;
      end
      if (st_valid_i && exp_ready) begin
        e.paddr = st_paddr_i;  e.data = st_data_i;  e.be = st_be_i;
        q.push_back(e);
        sent++;
      end
    end
    chk("wrap.writes", 64'(got), 64'd10);

    // Coalesce: A, B low half, B high half with grant low
    @(negedge clk_i);
    st_valid_i = 1'b0;  gnt_i = 1'b0;
    #1;
    chk("coal.empty0", 64'(empty_o), 64'd1);
    @(negedge clk_i);
    st_valid_i = 1'b1;  st_paddr_i = {44'h55, 12'h400};
    st_data_i = 64'h0123_4567_89AB_CDEF;  st_be_i = 8'h3C;
    @(negedge clk_i);
    st_paddr_i = {44'h55, 12'h408};
    st_data_i = 64'h1111_1111_AAAA_AAAA;  st_be_i = 8'h0F;
    @(negedge clk_i);
    st_paddr_i = {44'h55, 12'h40C};
    st_data_i = 64'hBBBB_BBBB_2222_2222;  st_be_i = 8'hF0;
    #1;
    chk("coal.ready_b2", 64'(st_ready_o), 64'd1);
    e.paddr = {44'h55, 12'h400};  e.data = 64'h0123_4567_89AB_CDEF;  e.be = 8'h3C;
    expectHead(e, "coal.a");
`ifdef STBUF_COALESCE_EN
    e.paddr = {44'h55, 12'h408};  e.data = 64'hBBBB_BBBB_AAAA_AAAA;  e.be = 8'hFF;
    expectHead(e, "coal.b_merged");
`else
    e.paddr = {44'h55, 12'h408};  e.data = 64'h1111_1111_AAAA_AAAA;  e.be = 8'h0F;
    expectHead(e, "coal.b_lo");
    e.paddr = {44'h55, 12'h40C};  e.data = 64'hBBBB_BBBB_2222_2222;  e.be = 8'hF0;
    expectHead(e, "coal.b_hi");
`endif
    @(negedge clk_i);
    gnt_i = 1'b0;
    #1;
    chk("coal.empty_end", 64'(empty_o), 64'd1);

    // Reset in the middle of operation drops buffered stores
    @(negedge clk_i);
    st_valid_i = 1'b1;  st_paddr_i = {44'h9, 12'h500};  st_be_i = 8'hFF;
    @(negedge clk_i);
    st_valid_i = 1'b0;  ld_index_i = 12'h500;
    #1;
    chk("midrst.match_before", 64'(ld_match_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst.empty", 64'(empty_o),    64'd1);
    chk("midrst.req",   64'(req_o),      64'd0);
    chk("midrst.match", 64'(ld_match_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    chk("midrst.empty_after", 64'(empty_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_store_queue.md
# dcache_store_queue

In-order committed-store queue that sits directly upstream of the store request port of the non-blocking L1 data cache. Committed stores are accepted on a valid/ready interface, buffered in a circular FIFO, and written to the dcache port one at a time using its req/gnt handshake. The queue also provides a same-word hazard check for the load path and an empty indication for fence/flush sequencing.

## Interface
- DEPTH, 4, number of queue entries; power of two, at least 2.
- INDEX_WIDTH, 12, dcache index width (page-offset bits).
- TAG_WIDTH, 44, dcache tag width. Physical address width is INDEX_WIDTH+TAG_WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  level drain request; blocks new stores while high.
- empty_o  out  1  queue holds no entries.
- st_valid_i  in  1  committed store present.
- st_ready_o  out  1  store accepted this cycle when st_valid_i is also high.
- st_paddr_i  in  INDEX_WIDTH+TAG_WIDTH  store physical address; bits [2:0] are ignored.
- st_data_i  in  64  store data, aligned to the 8-byte word.
- st_be_i  in  8  byte enables.
- ld_index_i  in  INDEX_WIDTH  load page-offset to check.
- ld_match_o  out  1  a buffered store targets the same 8-byte word.
- req_o  out  1  dcache write request.
- gnt_i  in  1  dcache grant; the write is complete on grant.
- index_o  out  INDEX_WIDTH  {head paddr[INDEX_WIDTH-1:3], 3'b000}.
- tag_o  out  TAG_WIDTH  head paddr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH].
- we_o  out  1  constant 1.
- wdata_o  out  64  head data.
- be_o  out  8  head byte enables.

## Operation
- State consists of the entry array (paddr, data, be), rd_ptr and wr_ptr (log2(DEPTH) bits each, wrapping modulo DEPTH), and count (log2(DEPTH)+1 bits, range 0..DEPTH).
- **Push:**
  - Occurs when st_valid_i && st_ready_o and the store is not coalesced.
  - The store is written at wr_ptr; wr_ptr increments and count increments.
- **st_ready_o:**
  - Equals !flush_i && (count<DEPTH || coalesce_hit).
  - It does not depend on gnt_i, so a full queue does not accept a store in the same cycle the head is granted.
- **Issue:**
  - req_o = (count!=0).
  - index_o, tag_o, wdata_o and be_o are driven from entry[rd_ptr] and stay stable until grant.
- **Pop:** when req_o && gnt_i, rd_ptr increments and count decrements.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **ld_match_o:**
  - Combinational OR over all valid entries of (entry paddr[INDEX_WIDTH-1:3] == ld_index_i[INDEX_WIDTH-1:3]).
  - Byte enables are ignored, so the check is conservative.
  - A store being pushed in the same cycle is not included.
- **empty_o:** equals (count==0), combinational.
- **Flush:**
  - While flush_i is high, no new stores are accepted and draining continues normally.
  - Fence logic waits for empty_o.
- **Mid-operation reset:** all entries are discarded and nothing is replayed. The store data is lost, and this is accepted behaviour.

## Timing
- **Reset values:**
  - Internal state: count=0, rd_ptr=0, wr_ptr=0.
  - Outputs: req_o=0, empty_o=1, ld_match_o=0, st_ready_o=!flush_i.
  - Entry contents are don't-care; only be is reset to 0.
- **Latency:**
  - A store pushed into an empty queue at edge N drives req_o high in the cycle after edge N.
  - There is no combinational path from st_* inputs to req_o.
- **Throughput:** one store per cycle with gnt_i tied high.
- **Occupancy and ld_match_o:** an entry becomes visible to ld_match_o the cycle after it is pushed, and stops being visible the cycle after it is granted.
- **Grant protocol:** req_o is never dropped without a grant. gnt_i arriving while req_o=0 is ignored.

## Configuration
- **STBUF_COALESCE_EN defined:**
  - coalesce_hit = st_valid_i && count>=2 && st_paddr_i[..:3] == entry[wr_ptr-1] paddr[..:3].
  - The head entry is never a merge target, because it may be under request.
  - On a hit, the store is merged into entry[wr_ptr-1]: bytes with st_be_i set overwrite the stored data, and be |= st_be_i.
  - A merge leaves pointers and count unchanged and is accepted even when the queue is full, but not while flush_i is high.
  - If the youngest entry is popped in the same cycle, then count>=2 guarantees it is not the head.
- **STBUF_COALESCE_EN undefined:** coalesce_hit=0 and every accepted store occupies its own entry.

## Test plan
- **Reset and single store:**
  - Stimulus: assert rst_ni low, then push paddr 0x8000_0010, data 0x1122334455667788, be 0xFF.
  - Required response: empty_o=1 during reset; req_o rises the next cycle with index_o=0x010 and tag_o=0x80000. With gnt_i held high, empty_o returns to 1 one cycle later.
- **Fill and back-pressure:**
  - Stimulus: hold gnt_i=0 and push 5 stores to distinct words.
  - Required response: st_ready_o=0 after the 4th push and the 5th store stalls. A single gnt makes ready 1 only in the following cycle; the drain order matches the push order.
- **Wrap-around with simultaneous push and pop:**
  - Stimulus: issue 10 stores with gnt_i toggling at random.
  - Required response: all 10 writes appear at the dcache port in order, with no loss or duplication and count bounded by 4.
- **Load hazard:**
  - Stimulus: buffer a store to 0x...0A8, then check ld_index_i=0x0AC and 0x0B0.
  - Required response: ld_match_o=1 for 0x0AC and ld_match_o=0 for 0x0B0. After grant, ld_match_o=0 for 0x0AC.
- **Flush:**
  - Stimulus: with 3 entries queued, raise flush_i and drive st_valid_i=1.
  - Required response: st_ready_o=0; empty_o=1 after 3 grants; nothing new is enqueued.
- **Coalesce (STBUF_COALESCE_EN only):**
  - Stimulus: gnt_i=0; push word A, then word B with be 0x0F and data low half 0xAAAAAAAA, then word B again with be 0xF0 and data high half 0xBBBBBBBB.
  - Required response: count=2 and the B entry has be=0xFF and data 0xBBBBBBBBAAAAAAAA. Without the macro, count=3.
